// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM encoding and
// parameter-legality rules evaluated at elaboration.
package sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_WIDTH = 2;

  // Legal when the operand is at least MIN_WIDTH wide and splits into whole chunks.
  function automatic bit params_ok(input int width, input int chunk);
    return (width >= MIN_WIDTH) && (chunk >= 1) && (chunk <= width) &&
           ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit ripple subtractor: {bo, d} = x - y - bi,
// built from a chain of full-subtractor bit cells.
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo = br[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock, LSB first.
// States: IDLE | waiting for start ; RUN | one chunk per cycle, N cycles.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $fatal(1, "serial_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             borrow;

  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK-1:0] y_chunk;
  logic [CHUNK-1:0] d_chunk;
  logic             bo_chunk;
  logic [WIDTH-1:0] res_next;
  logic             last;
  int               idx;

  // res_next already contains the chunk being finished, so the final
  // cycle can publish the complete result without an extra stage.
  always_comb begin
    idx      = int'(cnt) * CHUNK;
    x_chunk  = a_reg[idx +: CHUNK];
    y_chunk  = b_reg[idx +: CHUNK];
    res_next = res_reg;
    res_next[idx +: CHUNK] = d_chunk;
    last     = (cnt == CW'(N - 1));
  end

  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (x_chunk),
    .y  (y_chunk),
    .bi (borrow),
    .d  (d_chunk),
    .bo (bo_chunk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      borrow  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_reg <= res_next;
          borrow  <= bo_chunk;
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            bout  <= bo_chunk;
            ovf   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                     (res_next[WIDTH-1] != a_reg[WIDTH-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random 16/4 operations, plus exhaustive
// 4-bit runs with CHUNK = 1, 2 and 4, all against an arithmetic model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done, bout, ovf;
  logic [15:0] diff;

  logic       e_start [3];
  logic [3:0] e_a     [3];
  logic [3:0] e_b     [3];
  logic       e_bin   [3];
  logic       e_busy  [3];
  logic       e_done  [3];
  logic [3:0] e_diff  [3];
  logic       e_bout  [3];
  logic       e_ovf   [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(4), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(e_start[0]), .a(e_a[0]), .b(e_b[0]), .bin(e_bin[0]),
    .busy(e_busy[0]), .done(e_done[0]), .diff(e_diff[0]), .bout(e_bout[0]), .ovf(e_ovf[0])
  );

  serial_subtractor #(.WIDTH(4), .CHUNK(2)) dut_c2 (
    .clk(clk), .rst(rst), .start(e_start[1]), .a(e_a[1]), .b(e_b[1]), .bin(e_bin[1]),
    .busy(e_busy[1]), .done(e_done[1]), .diff(e_diff[1]), .bout(e_bout[1]), .ovf(e_ovf[1])
  );

  serial_subtractor #(.WIDTH(4), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst), .start(e_start[2]), .a(e_a[2]), .b(e_b[2]), .bin(e_bin[2]),
    .busy(e_busy[2]), .done(e_done[2]), .diff(e_diff[2]), .bout(e_bout[2]), .ovf(e_ovf[2])
  );

  // Reference: whole-word integer subtraction, borrow from sign of the result.
  function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                  output int d, output bit bo, output bit ov);
    longint full;
    int     msb_a, msb_b, msb_d;
    full  = longint'(av) - longint'(bv) - longint'(bi);
    d     = int'(full & ((64'd1 << w) - 1));
    bo    = (full < 0);
    msb_a = (av >> (w - 1)) & 1;
    msb_b = (bv >> (w - 1)) & 1;
    msb_d = (d  >> (w - 1)) & 1;
    ov    = (msb_a != msb_b) && (msb_d != msb_a);
  endfunction

  // Drives one 16-bit operation; lat = cycles from start to done (0 on timeout).
  task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         output int lat, output int bcnt);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_start[i] = 1'b0; e_a[i] = '0; e_b[i] = '0; e_bin[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0) begin errors++; $display("FAIL reset diff: got %h expected 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset bout: got %b expected 0", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_directed();
    logic [15:0] tv [6][2];
    logic        tbin [6];
    int lat, bcnt, d;
    bit bo, ov;
    tv = '{'{16'h1234, 16'h0235}, '{16'h0000, 16'h0001}, '{16'h8000, 16'h0001},
           '{16'h0005, 16'h0003}, '{16'h0003, 16'h0003}, '{16'h7FFF, 16'hFFFF}};
    tbin = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      do_op16(tv[t][0], tv[t][1], tbin[t], lat, bcnt);
      ref_sub(16, int'(tv[t][0]), int'(tv[t][1]), int'(tbin[t]), d, bo, ov);
      checks++; if (lat != 5) begin errors++; $display("FAIL directed%0d latency: got %0d expected 5", t, lat); end
      checks++; if (bcnt != 4) begin errors++; $display("FAIL directed%0d busy cycles: got %0d expected 4", t, bcnt); end
      checks++; if (diff !== d[15:0]) begin errors++; $display("FAIL directed%0d diff: got %h expected %h", t, diff, d[15:0]); end
      checks++; if (bout !== bo) begin errors++; $display("FAIL directed%0d bout: got %b expected %b", t, bout, bo); end
      checks++; if (ovf !== ov) begin errors++; $display("FAIL directed%0d ovf: got %b expected %b", t, ovf, ov); end
    end
  endtask

  task automatic test_ignore_midrun();
    int lat = 0;
    int extra = 0;
    @(negedge clk);
    a = 16'h1234; b = 16'h0235; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1; end
      else start = 1'b0;
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (lat != 5) begin errors++; $display("FAIL ignore latency: got %0d expected 5", lat); end
    checks++; if (diff !== 16'h0FFF) begin errors++; $display("FAIL ignore diff: got %h expected 0fff", diff); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore queued op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, lat2 = 0;
    do_op16(16'h00F0, 16'h000F, 1'b0, lat, bcnt);
    checks++; if (diff !== 16'h00E1) begin errors++; $display("FAIL b2b first diff: got %h expected 00e1", diff); end
    a = 16'h0001; b = 16'h0002; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin lat2 = c; break; end
      @(negedge clk);
    end
    checks++; if (lat2 != 5) begin errors++; $display("FAIL b2b second latency: got %0d expected 5", lat2); end
    checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL b2b second diff: got %h expected ffff", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL b2b second bout: got %b expected 1", bout); end
  endtask

  task automatic test_reset_midrun();
    int extra = 0;
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0) begin errors++; $display("FAIL midrst diff: got %h expected 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst bout: got %b expected 0", bout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst ovf: got %b expected 0", ovf); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL midrst late activity: got %0d cycles expected 0", extra); end
  endtask

  task automatic test_random();
    logic [15:0] av, bv;
    logic        bi;
    int lat, bcnt, d;
    bit bo, ov;
    for (int t = 0; t < 100; t++) begin
      av = 16'($urandom); bv = 16'($urandom); bi = 1'($urandom);
      do_op16(av, bv, bi, lat, bcnt);
      ref_sub(16, int'(av), int'(bv), int'(bi), d, bo, ov);
      checks++; if (lat != 5) begin errors++; $display("FAIL random%0d latency: got %0d expected 5", t, lat); end
      checks++; if ({diff, bout, ovf} !== {d[15:0], bo, ov}) begin
        errors++;
        $display("FAIL random%0d a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b expected diff=%h bout=%b ovf=%b",
                 t, av, bv, bi, diff, bout, ovf, d[15:0], bo, ov);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    int exp_lat [3] = '{5, 3, 2};
    int lat [3];
    logic [3:0] cd [3];
    logic cb [3], co [3];
    int d;
    bit bo, ov;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          @(negedge clk);
          for (int i = 0; i < 3; i++) begin
            e_a[i] = 4'(av); e_b[i] = 4'(bv); e_bin[i] = 1'(bi); e_start[i] = 1'b1;
            lat[i] = 0; cd[i] = '0; cb[i] = 1'b0; co[i] = 1'b0;
          end
          @(negedge clk);
          for (int i = 0; i < 3; i++) e_start[i] = 1'b0;
          for (int c = 1; c <= 8; c++) begin
            for (int i = 0; i < 3; i++) begin
              if (e_done[i] && lat[i] == 0) begin
                lat[i] = c; cd[i] = e_diff[i]; cb[i] = e_bout[i]; co[i] = e_ovf[i];
              end
            end
            if (c < 8) @(negedge clk);
          end
          ref_sub(4, av, bv, bi, d, bo, ov);
          for (int i = 0; i < 3; i++) begin
            checks++;
            if (lat[i] != exp_lat[i]) begin
              errors++;
              $display("FAIL w4 inst%0d latency a=%0d b=%0d bin=%0d: got %0d expected %0d",
                       i, av, bv, bi, lat[i], exp_lat[i]);
            end
            checks++;
            if ({cd[i], cb[i], co[i]} !== {d[3:0], bo, ov}) begin
              errors++;
              $display("FAIL w4 inst%0d a=%0d b=%0d bin=%0d: got diff=%h bout=%b ovf=%b expected diff=%h bout=%b ovf=%b",
                       i, av, bv, bi, cd[i], cb[i], co[i], d[3:0], bo, ov);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_midrun();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    test_exhaustive_w4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
